// File: rtl/serial_parallel_if.sv
// serial_parallel_if: serial line in, deserialised frame out
//  din         master->slave  serial bus line, idle = 1/Z, start bit = 0
//  bit_length  master->slave  index of frame MSB (frame = bit_length+1 bits)
//  dout        slave->master  last completed frame, zero-extended
//  dv_out      slave->master  one-cycle strobe when dout is updated
//  rx_busy     slave->master  high while a frame is being received
interface serial_parallel_if #(
  parameter int PARALLEL_PORT_WIDTH = 15,
  parameter int BIT_LENGTH = 4
);
  logic din;
  logic [BIT_LENGTH-1:0] bit_length;
  logic [PARALLEL_PORT_WIDTH-1:0] dout;
  logic dv_out;
  logic rx_busy;
  modport master (output din, bit_length, input dout, dv_out, rx_busy);
  modport slave (input din, bit_length, output dout, dv_out, rx_busy);
endinterface

// File: rtl/serial_parallel.sv
// serial_parallel: start-bit detecting MSB-first serial-to-parallel receiver
//  clk   clock, posedge
//  rstn  asynchronous active-low reset
//  bus   serial_parallel_if.slave (din, bit_length in; dout, dv_out, rx_busy out)
module serial_parallel #(
  parameter int PARALLEL_PORT_WIDTH = 15,
  parameter int BIT_LENGTH = 4
) (
  input logic clk,
  input logic rstn,
  serial_parallel_if.slave bus
);
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECEIVE} state_t;
  state_t state;
  logic [BIT_LENGTH-1:0] cnt;
  logic [PARALLEL_PORT_WIDTH-1:0] buf_q;
  logic start;
  logic bit_in;
  // only a clean 0 is a start/data zero; 1, Z and X all read as the pulled-up 1
  assign start = (bus.din === 1'b0);
  assign bit_in = ~start;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= WAIT_IDLE;
      cnt <= '0;
      buf_q <= '0;
      bus.dout <= '0;
      bus.dv_out <= 1'b0;
      bus.rx_busy <= 1'b0;
    end else begin
      bus.dv_out <= 1'b0;
      case (state)
        WAIT_IDLE: if (!start) state <= IDLE;
        IDLE: if (start) begin
          cnt <= bus.bit_length;
          buf_q <= '0;
          // a zero-length frame carries no payload, so nothing is reported
          state <= (bus.bit_length != '0) ? RECEIVE : WAIT_IDLE;
          bus.rx_busy <= (bus.bit_length != '0);
        end
        RECEIVE: if (cnt == '0) begin
          bus.dout <= buf_q | {{(PARALLEL_PORT_WIDTH-1){1'b0}}, bit_in};
          bus.dv_out <= 1'b1;
          bus.rx_busy <= 1'b0;
          state <= WAIT_IDLE;
        end else begin
          // indices beyond the port width are counted but not stored
          if (int'(cnt) < PARALLEL_PORT_WIDTH) buf_q[cnt] <= bit_in;
          cnt <= cnt - 1'b1;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_parallel.sv
// tb_serial_parallel: frame-level model of expected strobes/busy/data, checked every cycle
module tb_serial_parallel;
  localparam int W = 15;
  localparam int MAXC = 4096;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n = 0;
  int errors = 0;
  int checks = 0;
  int busy_seen;
  bit exp_busy [0:MAXC-1];
  bit exp_dv [0:MAXC-1];
  logic [W-1:0] exp_val [0:MAXC-1];
  logic [W-1:0] m_dout = '0;
  serial_parallel_if #(.PARALLEL_PORT_WIDTH(W), .BIT_LENGTH(4)) bus ();
  serial_parallel #(.PARALLEL_PORT_WIDTH(W), .BIT_LENGTH(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) n <= n + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rstn) m_dout = '0;
    else if (exp_dv[n]) m_dout = exp_val[n];
    chk("dv_out", 32'(bus.dv_out), 32'(rstn && exp_dv[n]));
    chk("rx_busy", 32'(bus.rx_busy), 32'(rstn && exp_busy[n]));
    chk("dout", 32'(bus.dout), 32'(m_dout));
  end
  task automatic step(input logic d);
    bus.din = d;
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input int len, input logic [15:0] p, input int nb, input bit chg);
    int e0;
    e0 = n + 1;
    bus.bit_length = 4'(len);
    if (len > 0) begin
      for (int k = e0; k <= e0 + len; k++) exp_busy[k] = 1'b1;
      exp_dv[e0 + len + 1] = 1'b1;
      exp_val[e0 + len + 1] = W'(32'(p) & ((1 << (len + 1)) - 1));
    end
    step(1'b0);
    if (chg) bus.bit_length = 4'd3;
    busy_seen = int'(bus.rx_busy);
    if (len > 0)
      for (int i = len; i >= 0 && (len - i) < nb; i--) begin
        step(p[i]);
        busy_seen += int'(bus.rx_busy);
      end
  endtask
  task automatic reset_now();
    for (int k = n + 1; k < MAXC; k++) begin
      exp_busy[k] = 1'b0;
      exp_dv[k] = 1'b0;
    end
    rstn = 1'b0;
    step(1'b0);
    step(1'b0);
    rstn = 1'b1;
  endtask
  initial begin
    bus.din = 1'b1;
    bus.bit_length = '0;
    repeat (3) step(1'b1);
    rstn = 1'b1;
    step(1'b1);
    // 1: 8-bit frame A5
    frame(7, 16'h00A5, 99, 1'b0);
    chk("t1_dout", 32'(bus.dout), 32'h00A5);
    chk("t1_dv", 32'(bus.dv_out), 32'd1);
    chk("t1_busy_cycles", busy_seen, 8);
    step(1'b1);
    // 3: zero-length frame
    frame(0, 16'h0000, 99, 1'b0);
    step(1'b1);
    step(1'b1);
    chk("t3_dout_held", 32'(bus.dout), 32'h00A5);
    // 2: back-to-back full-width frames
    frame(14, 16'h7FFF, 99, 1'b0);
    chk("t2_dout_a", 32'(bus.dout), 32'h7FFF);
    step(1'b1);
    frame(14, 16'h4001, 99, 1'b0);
    chk("t2_dout_b", 32'(bus.dout), 32'h4001);
    step(1'b1);
    // 5: bit_length changes mid-frame
    frame(7, 16'h003C, 99, 1'b1);
    chk("t5_dout", 32'(bus.dout), 32'h003C);
    chk("t5_busy_cycles", busy_seen, 8);
    step(1'b1);
    // 6: long idle
    repeat (100) step(1'b1);
    chk("t6_dout_held", 32'(bus.dout), 32'h003C);
    chk("t6_busy", 32'(bus.rx_busy), 32'd0);
    // frame longer than the port: MSB sample dropped
    frame(15, 16'hB00F, 99, 1'b0);
    chk("drop_dout", 32'(bus.dout), 32'h300F);
    step(1'b1);
    // 4: reset mid-frame, zeros after release ignored
    frame(7, 16'h00E7, 3, 1'b0);
    reset_now();
    chk("t4_dout_reset", 32'(bus.dout), 32'h0000);
    chk("t4_dv_reset", 32'(bus.dv_out), 32'd0);
    bus.bit_length = 4'd7;
    step(1'b0);
    step(1'b0);
    chk("t4_no_false_start", 32'(bus.rx_busy), 32'd0);
    step(1'b1);
    frame(7, 16'h005A, 99, 1'b0);
    chk("t4_dout_after", 32'(bus.dout), 32'h005A);
    step(1'b1);
    step(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
